burst_ram_arbiter: RTL and testbench

- Shares one burst RAM command/data port (PSRAM controller IP) between two cache clients, e.g. instruction cache (client 0) and data cache (client 1).
- Grants the port to one client for a whole transaction: one command plus its 4-beat burst.
- Enforces the minimum command-to-command interval across both clients.
- Routes read data back to the owning client only.

---
 rtl/burst_ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// Two-client arbiter for one shared burst RAM port: each grant covers one command plus its burst.
// Define BURST_RAM_ARBITER_FIXED_PRIORITY_EN for fixed priority (client 0 wins ties); default is round robin.
module burst_ram_arbiter #(
   parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
   parameter int COMMAND_DELAY_INTERVAL   = 13,
   parameter int BURST_BEATS              = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                c0_req,
   output logic                                c0_gnt,
   input  logic                                c0_cmd,
   input  logic                                c0_cmd_en,
   input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] c0_addr,
   input  logic [63:0]                         c0_wr_data,
   input  logic [7:0]                          c0_data_mask,
   output logic [63:0]                         c0_rd_data,
   output logic                                c0_rd_data_valid,
   input  logic                                c1_req,
   output logic                                c1_gnt,
   input  logic                                c1_cmd,
   input  logic                                c1_cmd_en,
   input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] c1_addr,
   input  logic [63:0]                         c1_wr_data,
   input  logic [7:0]                          c1_data_mask,
   output logic [63:0]                         c1_rd_data,
   output logic                                c1_rd_data_valid,
   output logic                                br_cmd,
   output logic                                br_cmd_en,
   output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
   output logic [63:0]                         br_wr_data,
   output logic [7:0]                          br_data_mask,
   input  logic [63:0]                         br_rd_data,
   input  logic                                br_rd_data_valid
);

   localparam int DLY_W  = $clog2(COMMAND_DELAY_INTERVAL + 1);
   localparam int BEAT_W = $clog2(BURST_BEATS) + 1;

   typedef enum logic [1:0] {IDLE, GRANT, READ, WRITE} state_t;

   state_t              state, state_nxt;
   logic [1:0]          gnt, gnt_nxt;
   logic [DLY_W-1:0]    delay_cnt;
   logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
   logic                owner, own_req, own_cmd, own_cmd_en, last_beat, pick_c1;

   assign owner      = gnt[1];
   assign own_req    = owner ? c1_req    : c0_req;
   assign own_cmd    = owner ? c1_cmd    : c0_cmd;
   assign own_cmd_en = owner ? c1_cmd_en : c0_cmd_en;
   assign last_beat  = (beat_cnt == BEAT_W'(BURST_BEATS - 1));

`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
   assign pick_c1 = c1_req && !c0_req;
`else
   logic last_served;
   logic txn_done;

   assign txn_done = ((state == READ) && br_rd_data_valid && last_beat) ||
                     ((state == WRITE) && last_beat);

   // Starts at 1 so client 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)           last_served <= 1'b1;
      else if (txn_done) last_served <= owner;
   end

   assign pick_c1 = c1_req && (!c0_req || !last_served);
`endif

   // NOTE: every variable is given a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      beat_nxt  = beat_cnt;
      br_cmd_en = 1'b0;
      case (state)
         IDLE: begin
            if ((delay_cnt == '0) && (c0_req || c1_req)) begin
               state_nxt = GRANT;
               gnt_nxt   = pick_c1 ? 2'b10 : 2'b01;
            end
         end
         GRANT: begin
            if (own_cmd_en) begin
               br_cmd_en = 1'b1;
               state_nxt = own_cmd ? WRITE : READ;
               // The command cycle already carries write beat 0.
               beat_nxt  = own_cmd ? BEAT_W'(1) : '0;
            end else if (!own_req) begin
               state_nxt = IDLE;
               gnt_nxt   = 2'b00;
            end
         end
         READ: begin
            if (br_rd_data_valid) begin
               beat_nxt = beat_cnt + BEAT_W'(1);
               if (last_beat) begin
                  state_nxt = IDLE;
                  gnt_nxt   = 2'b00;
               end
            end
         end
         WRITE: begin
            beat_nxt = beat_cnt + BEAT_W'(1);
            if (last_beat) begin
               state_nxt = IDLE;
               gnt_nxt   = 2'b00;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 2'b00;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= 2'b00;
         beat_cnt  <= '0;
         delay_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         beat_cnt <= beat_nxt;
         if (br_cmd_en)             delay_cnt <= DLY_W'(COMMAND_DELAY_INTERVAL);
         else if (delay_cnt != '0)  delay_cnt <= delay_cnt - DLY_W'(1);
      end
   end

   always_comb begin
      br_cmd       = 1'b0;
      br_addr      = '0;
      br_wr_data   = '0;
      br_data_mask = '0;
      if (gnt[0]) begin
         br_cmd       = c0_cmd;
         br_addr      = c0_addr;
         br_wr_data   = c0_wr_data;
         br_data_mask = c0_data_mask;
      end else if (gnt[1]) begin
         br_cmd       = c1_cmd;
         br_addr      = c1_addr;
         br_wr_data   = c1_wr_data;
         br_data_mask = c1_data_mask;
      end
   end

   assign c0_gnt           = gnt[0];
   assign c1_gnt           = gnt[1];
   assign c0_rd_data       = br_rd_data;
   assign c1_rd_data       = br_rd_data;
   assign c0_rd_data_valid = (state == READ) && gnt[0] && br_rd_data_valid;
   assign c1_rd_data_valid = (state == READ) && gnt[1] && br_rd_data_valid;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: a per-cycle vector table for a single read, plus
// hand-written sequences for write, contention, command interval, abort and mid-burst reset.
module tb_burst_ram_arbiter;

   localparam int AW = 21;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic          clk = 1'b0;
   logic          rst;
   logic          c0_req, c0_gnt, c0_cmd, c0_cmd_en, c0_rd_data_valid;
   logic [AW-1:0] c0_addr;
   logic [63:0]   c0_wr_data, c0_rd_data;
   logic [7:0]    c0_data_mask;
   logic          c1_req, c1_gnt, c1_cmd, c1_cmd_en, c1_rd_data_valid;
   logic [AW-1:0] c1_addr;
   logic [63:0]   c1_wr_data, c1_rd_data;
   logic [7:0]    c1_data_mask;
   logic          br_cmd, br_cmd_en, br_rd_data_valid;
   logic [AW-1:0] br_addr;
   logic [63:0]   br_wr_data, br_rd_data;
   logic [7:0]    br_data_mask;

   int total = 0;
   int bad   = 0;
   int overlap_cnt = 0;

   burst_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c0_gnt(c0_gnt), .c0_cmd(c0_cmd), .c0_cmd_en(c0_cmd_en),
      .c0_addr(c0_addr), .c0_wr_data(c0_wr_data), .c0_data_mask(c0_data_mask),
      .c0_rd_data(c0_rd_data), .c0_rd_data_valid(c0_rd_data_valid),
      .c1_req(c1_req), .c1_gnt(c1_gnt), .c1_cmd(c1_cmd), .c1_cmd_en(c1_cmd_en),
      .c1_addr(c1_addr), .c1_wr_data(c1_wr_data), .c1_data_mask(c1_data_mask),
      .c1_rd_data(c1_rd_data), .c1_rd_data_valid(c1_rd_data_valid),
      .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
      .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
      .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (c0_gnt && c1_gnt) overlap_cnt++;
      assert (!(c0_gnt && c1_gnt)) else $error("both grants high");
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs are applied just after the falling edge; outputs are checked 1 time unit later.
   task automatic next();
      @(negedge clk);
   endtask

   typedef struct {
      logic          req0, cmd_en0;
      logic [AW-1:0] addr0;
      logic          req1, cmd_en1;
      logic          rdv;
      logic [63:0]   rdd;
      logic          e_gnt0, e_gnt1, e_cmd_en, e_v0, e_v1;
      logic [AW-1:0] e_addr;
   } vec_t;

   vec_t vecs[8];
   int   exp_order[6];
   int   done0, done1, n, k, own;

   initial begin
      // Single read by client 0, with client-1 command noise and idle read-valid noise.
      vecs[0] = '{H, L, 21'h00100, L, H, H, 64'h99, L, L, L, L, L, 21'h0};
      vecs[1] = '{H, H, 21'h00100, L, L, L, 64'h0,  H, L, H, L, L, 21'h00100};
      vecs[2] = '{L, L, 21'h00100, L, H, L, 64'h0,  H, L, L, L, L, 21'h00100};
      vecs[3] = '{L, L, 21'h00100, L, L, H, 64'h1,  H, L, L, H, L, 21'h00100};
      vecs[4] = '{L, L, 21'h00100, L, L, H, 64'h2,  H, L, L, H, L, 21'h00100};
      vecs[5] = '{L, L, 21'h00100, L, L, H, 64'h3,  H, L, L, H, L, 21'h00100};
      vecs[6] = '{L, L, 21'h00100, L, L, H, 64'h4,  H, L, L, H, L, 21'h00100};
      vecs[7] = '{L, L, 21'h00100, L, L, H, 64'h5,  L, L, L, L, L, 21'h0};
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
      exp_order = '{0, 0, 0, 1, 1, 1};
`else
      exp_order = '{0, 1, 0, 1, 0, 1};
`endif

      rst = 1'b1;
      c0_req = 0; c0_cmd = 0; c0_cmd_en = 0; c0_addr = 21'h1FFFFF;
      c0_wr_data = 64'hDEAD_BEEF_0000_1111; c0_data_mask = 8'hFF;
      c1_req = 0; c1_cmd = 0; c1_cmd_en = 0; c1_addr = 21'h0ABCD;
      c1_wr_data = 64'h1234; c1_data_mask = 8'h3C;
      br_rd_data = 64'h0; br_rd_data_valid = 0;
      repeat (3) next();
      rst = 1'b0;

      // Reset state: no grant, port outputs all zero despite non-zero client inputs.
      next(); #1;
      check("rst_gnt", {c1_gnt, c0_gnt}, 2'b00);
      check("rst_cmd_en", br_cmd_en, 1'b0);
      check("rst_addr", br_addr, 0);
      check("rst_wr_data", br_wr_data, 0);
      check("rst_mask", br_data_mask, 0);
      check("rst_valid", {c1_rd_data_valid, c0_rd_data_valid}, 2'b00);

      for (int i = 0; i < 8; i++) begin
         next();
         c0_req = vecs[i].req0; c0_cmd_en = vecs[i].cmd_en0; c0_addr = vecs[i].addr0; c0_cmd = 1'b0;
         c1_req = vecs[i].req1; c1_cmd_en = vecs[i].cmd_en1;
         br_rd_data_valid = vecs[i].rdv; br_rd_data = vecs[i].rdd;
         #1;
         check($sformatf("vec%0d_gnt", i), {c1_gnt, c0_gnt}, {vecs[i].e_gnt1, vecs[i].e_gnt0});
         check($sformatf("vec%0d_cmd_en", i), br_cmd_en, vecs[i].e_cmd_en);
         check($sformatf("vec%0d_cmd", i), br_cmd, 1'b0);
         check($sformatf("vec%0d_addr", i), br_addr, vecs[i].e_addr);
         check($sformatf("vec%0d_valid", i), {c1_rd_data_valid, c0_rd_data_valid},
               {vecs[i].e_v1, vecs[i].e_v0});
         check($sformatf("vec%0d_rd0", i), c0_rd_data, vecs[i].rdd);
         check($sformatf("vec%0d_rd1", i), c1_rd_data, vecs[i].rdd);
      end
      br_rd_data_valid = 0; c1_cmd_en = 0;

      // Re-request right away: command was in cycle 1, so the grant must appear in cycle 16.
      c0_req = 1;
      n = 0;
      do begin next(); #1; n++; end while (!c0_gnt && n < 40);
      check("read_regrant_cycle", 7 + n, 16);

      // Abort without a command: grant drops and the delay counter is not loaded.
      c0_req = 0;
      next(); #1;
      check("abort_drop", c0_gnt, 1'b0);
      c0_req = 1;
      next(); #1;
      check("abort_no_delay", c0_gnt, 1'b1);
      c0_req = 0;
      next(); br_rd_data_valid = 1; br_rd_data = 64'h77; #1;
      check("idle_noise_gnt", c0_gnt, 1'b0);
      check("idle_noise_valid", {c1_rd_data_valid, c0_rd_data_valid}, 2'b00);
      br_rd_data_valid = 0;

      // Write burst from client 1, beat 0 on the command cycle.
      next(); c1_req = 1; c1_cmd = 1; c1_addr = 21'h00040; #1;
      check("wr_pre_gnt", c1_gnt, 1'b0);
      next(); c1_req = 0; c1_cmd_en = 1; c1_wr_data = 64'hA0; c1_data_mask = 8'h0F; #1;
      check("wr_gnt", {c1_gnt, c0_gnt}, 2'b10);
      check("wr_cmd_en", br_cmd_en, 1'b1);
      check("wr_cmd", br_cmd, 1'b1);
      check("wr_addr", br_addr, 21'h00040);
      check("wr_beat0", br_wr_data, 64'hA0);
      check("wr_mask0", br_data_mask, 8'h0F);
      for (int b = 1; b < 4; b++) begin
         next(); c1_cmd_en = 0; c1_wr_data = 64'hA0 + 64'(b); c1_data_mask = 8'h0F ^ 8'(b); #1;
         check($sformatf("wr_beat%0d", b), br_wr_data, 64'hA0 + 64'(b));
         check($sformatf("wr_mask%0d", b), br_data_mask, 8'h0F ^ 8'(b));
         check($sformatf("wr_cmd_en_b%0d", b), br_cmd_en, 1'b0);
         check($sformatf("wr_gnt_b%0d", b), c1_gnt, 1'b1);
      end
      next(); #1;
      check("wr_end_gnt", c1_gnt, 1'b0);
      c1_cmd = 0;

      // Contention: both clients want three reads each.
      done0 = 0; done1 = 0;
      for (int t = 0; t < 6; t++) begin
         n = 0;
         do begin
            next(); c0_req = (done0 < 3); c1_req = (done1 < 3); #1; n++;
         end while (!(c0_gnt || c1_gnt) && n < 100);
         own = c1_gnt ? 1 : (c0_gnt ? 0 : 2);
         check($sformatf("ct_order%0d", t), own, exp_order[t]);
         if (own == 2) break;
         if (own == 0) begin c0_cmd_en = 1; c0_cmd = 0; end
         else          begin c1_cmd_en = 1; c1_cmd = 0; end
         next(); c0_cmd_en = 0; c1_cmd_en = 0;
         for (int b = 0; b < 4; b++) begin
            br_rd_data_valid = 1; br_rd_data = 64'(t * 16 + b); #1;
            check($sformatf("ct%0d_v_own", t), own == 1 ? c1_rd_data_valid : c0_rd_data_valid, 1'b1);
            check($sformatf("ct%0d_v_other", t), own == 1 ? c0_rd_data_valid : c1_rd_data_valid, 1'b0);
            if (b == 3) begin
               if (own == 0) done0++; else done1++;
            end
            next();
         end
         br_rd_data_valid = 0;
      end
      c0_req = 0; c1_req = 0;
      check("ct_done", {done1[3:0], done0[3:0]}, 8'h33);
      check("gnt_overlap", overlap_cnt, 0);

      // Interval: client 1 requests one cycle after client 0's command.
      repeat (20) next();
      c0_req = 1; #1;
      next(); #1;
      check("iv_gnt0", c0_gnt, 1'b1);
      c0_cmd_en = 1; c0_cmd = 0; c0_addr = 21'h00123; #1;
      check("iv_cmd_en", br_cmd_en, 1'b1);
      next(); c0_cmd_en = 0; c0_req = 0; c1_req = 1;
      k = 1;
      while (k < 40) begin
         br_rd_data_valid = (k <= 4); #1;
         if (c1_gnt) break;
         next(); k++;
      end
      br_rd_data_valid = 0;
      check("iv_cycles", k, 15);
      c1_req = 0;
      next();

      // Reset after two read beats.
      next(); c0_req = 1; #1;
      next(); #1;
      check("rr_gnt", c0_gnt, 1'b1);
      c0_cmd_en = 1; c0_cmd = 0;
      next(); c0_cmd_en = 0; br_rd_data_valid = 1; br_rd_data = 64'h11; #1;
      check("rr_beat0", c0_rd_data_valid, 1'b1);
      next(); br_rd_data = 64'h22; #1;
      check("rr_beat1", c0_rd_data_valid, 1'b1);
      next(); br_rd_data_valid = 0; rst = 1; c0_cmd_en = 1;
      next(); #1;
      check("rr_gnt_after", {c1_gnt, c0_gnt}, 2'b00);
      check("rr_cmd_en_after", br_cmd_en, 1'b0);
      rst = 0; c0_cmd_en = 0; br_rd_data_valid = 1; #1;
      check("rr_idle_valid", {c1_rd_data_valid, c0_rd_data_valid}, 2'b00);
      next(); br_rd_data_valid = 0; #1;
      check("rr_regrant", c0_gnt, 1'b1);
      c0_req = 0;
      next(); next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
